serial_adder: RTL
=================

# serial_adder

Bit-serial ripple adder. Accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake and adds them one bit per clock through a single 1-bit full-adder cell with a registered carry. Returns the WIDTH-bit sum and carry-out through a second valid/ready handshake. It sits in the datapath wherever area matters more than latency, alongside the combinational gate-level adders.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (≥2)

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  A+B+c_in modulo 2^WIDTH
- c_out  output  1  carry out of bit WIDTH-1

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the block loads a and b into shift registers, loads carry reg=c_in, clears bit counter and result reg, and moves to SHIFT.
- SHIFT: in_ready=0. Each cycle, the block feeds the LSBs of A/B and carry reg to the FA cell, shifts A/B right by 1, shifts the sum bit into the MSB of the result reg (right shift), sets carry reg=cell carry, and increments the counter. When counter==WIDTH-1 at the edge, it moves to DONE.
- DONE: out_valid=1. sum=result reg, c_out=carry reg, both held stable. On out_valid&&out_ready, it moves to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Arithmetic is unsigned modulo 2^WIDTH with carry out. {c_out,sum} equals a+b+c_in exactly.
- sum and c_out are checked only while out_valid=1. During SHIFT they show the partially shifted contents.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, c_out=0, all internal registers 0.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Throughput with out_ready tied high and in_valid held: one result per WIDTH+2 cycles (accept edge, WIDTH shift edges, release edge).
- Backpressure: DONE holds indefinitely. Outputs do not change until the handshake completes.
- Reset mid-operation: rst_n low at any time returns immediately to reset values. The in-flight operation is discarded and never produces out_valid.
- The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

## Configuration
- SERIAL_ADDER_OVF_EN defined: adds output port `ovf` (1 bit) = signed two's-complement overflow, i.e. carry into bit WIDTH-1 XOR c_out.
  - The carry into the MSB is captured in a register on the final SHIFT cycle.
  - ovf is valid with out_valid and resets to 0.
- Undefined: no `ovf` port and no extra register.

## Structure
- Shared package `serial_adder_pkg`: state enum type (IDLE, SHIFT, DONE) and default WIDTH constant.
- One sub-module `fa_cell`: 1-bit full adder with sum = a^b^c and carry = ab|ac|bc, instantiated once.

## Test plan
- Reset: hold rst_n low 3 cycles → in_ready=1, out_valid=0, sum=8'h00, c_out=0 (ovf=0).
- a=8'h3C, b=8'h5A, c_in=0 → out_valid exactly 8 cycles after accept; sum=8'h96, c_out=0, ovf=1.
- Carry chain: a=8'hFF, b=8'h01, c_in=0 → sum=8'h00, c_out=1, ovf=0. Then a=8'hFF, b=8'hFF, c_in=1 → sum=8'hFF, c_out=1, ovf=0.
- Backpressure: out_ready low for 5 cycles in DONE with in_valid pulsing → out_valid, sum and c_out stable. No new operand accepted until 1 cycle after the handshake.
- Reset mid-SHIFT (3rd shift cycle) → all outputs return to reset values immediately. No out_valid appears. The next operation a=8'h01, b=8'h01 gives sum=8'h02.
- Back-to-back: in_valid and out_ready held high, 4 random operand pairs → results match a+b+c_in, with out_valid rising every 10 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

  localparam int SA_WIDTH_DFLT = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; slave = adder side, master = client side.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag to the result side.
interface serial_adder_if import serial_adder_pkg::*; #(
  parameter int WIDTH = SA_WIDTH_DFLT
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport slave  (input in_valid, a, b, c_in, out_ready,
                  output in_ready, out_valid, sum, c_out, ovf);
  modport master (output in_valid, a, b, c_in, out_ready,
                  input in_ready, out_valid, sum, c_out, ovf);
`else
  modport slave  (input in_valid, a, b, c_in, out_ready,
                  output in_ready, out_valid, sum, c_out);
  modport master (output in_valid, a, b, c_in, out_ready,
                  input in_ready, out_valid, sum, c_out);
`endif

endinterface

// File: rtl/serial_adder_fa_cell.sv
// 1-bit full adder cell; purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: result valid WIDTH cycles after accept, held in DONE until out_ready.
// SERIAL_ADDER_OVF_EN adds a signed-overflow output captured on the final shift.
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = SA_WIDTH_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             fa_sum, fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic             cmsb_q, cmsb_d;
`endif

  fa_cell u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
    cmsb_d      = cmsb_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = bus.c_in;
          cnt_d      = '0;
          res_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
`ifdef SERIAL_ADDER_OVF_EN
          cmsb_d     = 1'b0;
`endif
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB; fa_carry becomes c_out
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          cmsb_d      = carry_q;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q      <= cmsb_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = res_q;
  assign bus.c_out     = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf       = cmsb_q ^ carry_q;
`endif

endmodule
